// File: rtl/game_config.sv
// Screen geometry and coordinate widths shared by all game blocks.
package game_config;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int X_W      = 10;
  localparam int Y_W      = 10;

endpackage

// File: rtl/game_strobe_gen.sv
// Free-running counter producing a one-cycle motion strobe every 2^STROBE_LOG cycles.
module game_strobe_gen #(
  parameter int STROBE_LOG = 20
) (
  input  logic clk,
  input  logic rst,
  output logic strobe
);

  logic [STROBE_LOG-1:0] cnt_q;
  logic [STROBE_LOG-1:0] cnt_d;

  assign cnt_d  = cnt_q + 1'b1;
  assign strobe = &cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_sprite_motion.sv
// One sprite: position/velocity registers, strobed motion, on-screen flag and raster hit test.
module game_sprite_motion
  import game_config::*;
#(
  parameter int SPRITE_W   = 8,
  parameter int SPRITE_H   = 8,
  parameter int STROBE_LOG = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_xy,
  input  logic                write_dxy,
  input  logic                enable_update,
  input  logic [X_W-1:0]      sprite_write_x,
  input  logic [Y_W-1:0]      sprite_write_y,
  input  logic signed [1:0]   sprite_write_dx,
  input  logic signed [1:0]   sprite_write_dy,
  input  logic [X_W-1:0]      pixel_x,
  input  logic [Y_W-1:0]      pixel_y,
  output logic [X_W-1:0]      sprite_x,
  output logic [Y_W-1:0]      sprite_y,
  output logic                within_screen,
  output logic                hit
);

  localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W - SPRITE_W);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H - SPRITE_H);

  logic                 strobe;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic signed [1:0]    dx_q, dx_d;
  logic signed [1:0]    dy_q, dy_d;
  logic                 within_q, within_d;
  logic                 hit_q, hit_d;
  logic [X_W:0]         x_e, x_end, px_e;
  logic [Y_W:0]         y_e, y_end, py_e;

  game_strobe_gen #(.STROBE_LOG(STROBE_LOG)) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .strobe (strobe)
  );

  // Hit window is evaluated one bit wider so x+SPRITE_W cannot wrap.
  assign x_e   = {1'b0, x_q};
  assign y_e   = {1'b0, y_q};
  assign px_e  = {1'b0, pixel_x};
  assign py_e  = {1'b0, pixel_y};
  assign x_end = x_e + (X_W+1)'(SPRITE_W);
  assign y_end = y_e + (Y_W+1)'(SPRITE_H);

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    // A load wins over motion; the strobe of that cycle is simply lost.
    if (write_xy) begin
      x_d = sprite_write_x;
      y_d = sprite_write_y;
    end else if (strobe && enable_update) begin
      x_d = x_q + {{(X_W-2){dx_q[1]}}, dx_q};
      y_d = y_q + {{(Y_W-2){dy_q[1]}}, dy_q};
    end
    if (write_dxy) begin
      dx_d = sprite_write_dx;
      dy_d = sprite_write_dy;
    end
    within_d = (x_q <= X_LIM) && (y_q <= Y_LIM);
    hit_d    = (px_e >= x_e) && (px_e < x_end) && (py_e >= y_e) && (py_e < y_end);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      within_q <= 1'b1;
      hit_q    <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      within_q <= within_d;
      hit_q    <= hit_d;
    end
  end

  assign sprite_x      = x_q;
  assign sprite_y      = y_q;
  assign within_screen = within_q;
  assign hit           = hit_q;

endmodule

// File: tb/tb_game_sprite_motion.sv
// Directed bench for game_sprite_motion with a 4-cycle motion strobe.
module tb_game_sprite_motion;

  logic              clk;
  logic              rst;
  logic              write_xy;
  logic              write_dxy;
  logic              enable_update;
  logic [9:0]        sprite_write_x;
  logic [9:0]        sprite_write_y;
  logic signed [1:0] sprite_write_dx;
  logic signed [1:0] sprite_write_dy;
  logic [9:0]        pixel_x;
  logic [9:0]        pixel_y;
  logic [9:0]        sprite_x;
  logic [9:0]        sprite_y;
  logic              within_screen;
  logic              hit;

  int total = 0;
  int bad   = 0;

  game_sprite_motion #(.SPRITE_W(8), .SPRITE_H(8), .STROBE_LOG(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .write_xy        (write_xy),
    .write_dxy       (write_dxy),
    .enable_update   (enable_update),
    .sprite_write_x  (sprite_write_x),
    .sprite_write_y  (sprite_write_y),
    .sprite_write_dx (sprite_write_dx),
    .sprite_write_dy (sprite_write_dy),
    .pixel_x         (pixel_x),
    .pixel_y         (pixel_y),
    .sprite_x        (sprite_x),
    .sprite_y        (sprite_y),
    .within_screen   (within_screen),
    .hit             (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_xy(input int x, input int y);
    write_xy       = 1'b1;
    sprite_write_x = 10'(x);
    sprite_write_y = 10'(y);
  endtask

  task automatic set_dxy(input logic signed [1:0] dx, input logic signed [1:0] dy);
    write_dxy       = 1'b1;
    sprite_write_dx = dx;
    sprite_write_dy = dy;
  endtask

  // pixel_x, pixel_y, expected hit for sprite at (20,30)
  int hit_vec [5][3] = '{'{28,37,0}, '{20,30,1}, '{19,30,0}, '{27,38,0}, '{24,29,0}};

  initial begin
    rst = 1'b1; write_xy = 1'b0; write_dxy = 1'b0; enable_update = 1'b0;
    sprite_write_x = '0; sprite_write_y = '0; sprite_write_dx = '0; sprite_write_dy = '0;
    pixel_x = 10'd500; pixel_y = 10'd400;
    @(negedge clk);
    chk("rst_x", 32'(sprite_x), 0);
    chk("rst_within", 32'(within_screen), 1);
    chk("rst_hit", 32'(hit), 0);

    // Release; strobes then land on posedges 4, 8, 12, ...
    rst = 1'b0; enable_update = 1'b1;
    set_xy(100, 50); set_dxy(2'sb01, 2'sb11);
    tick(1);                                   // P1
    write_xy = 1'b0; write_dxy = 1'b0;
    chk("load_x", 32'(sprite_x), 100);
    chk("load_y", 32'(sprite_y), 50);
    tick(3);                                   // P4
    chk("step1_x", 32'(sprite_x), 101);
    chk("step1_y", 32'(sprite_y), 49);
    tick(8);                                   // P12
    chk("step3_x", 32'(sprite_x), 103);
    chk("step3_y", 32'(sprite_y), 47);
    chk("step3_within", 32'(within_screen), 1);
    enable_update = 1'b0;
    tick(8);                                   // P20
    chk("hold_x", 32'(sprite_x), 103);

    // Leftward wrap from x=0
    set_xy(0, 0); set_dxy(2'sb11, 2'sb00);
    tick(1);                                   // P21
    write_xy = 1'b0; write_dxy = 1'b0; enable_update = 1'b1;
    chk("wrap_pre_x", 32'(sprite_x), 0);
    tick(3);                                   // P24
    chk("wrap_x", 32'(sprite_x), 1023);
    chk("wrap_within_lag", 32'(within_screen), 1);
    tick(1);                                   // P25
    chk("wrap_within", 32'(within_screen), 0);
    enable_update = 1'b0;

    // Right edge boundary
    set_xy(632, 0); set_dxy(2'sb01, 2'sb00);
    tick(1);                                   // P26
    write_xy = 1'b0; write_dxy = 1'b0;
    chk("edge_x", 32'(sprite_x), 632);
    tick(1);                                   // P27
    chk("edge_within", 32'(within_screen), 1);
    enable_update = 1'b1;
    tick(1);                                   // P28
    chk("edge_x633", 32'(sprite_x), 633);
    tick(1);                                   // P29
    chk("edge_within633", 32'(within_screen), 0);
    tick(3);                                   // P32
    chk("edge_x634", 32'(sprite_x), 634);
    enable_update = 1'b0;

    // Bottom edge boundary
    set_xy(0, 473);
    tick(1);                                   // P33
    write_xy = 1'b0;
    chk("bot_y", 32'(sprite_y), 473);
    tick(1);                                   // P34
    chk("bot_within473", 32'(within_screen), 0);
    set_xy(0, 472);
    tick(1);                                   // P35
    write_xy = 1'b0;
    tick(1);                                   // P36
    chk("bot_within472", 32'(within_screen), 1);

    // Load coincident with strobe wins, strobe not deferred
    enable_update = 1'b1;
    tick(3);                                   // P39
    chk("pre_coinc_x", 32'(sprite_x), 0);
    set_xy(10, 10);
    tick(1);                                   // P40
    write_xy = 1'b0;
    chk("coinc_x", 32'(sprite_x), 10);
    tick(1);                                   // P41
    chk("nodefer_x", 32'(sprite_x), 10);
    tick(3);                                   // P44
    chk("next_strobe_x", 32'(sprite_x), 11);

    // Motion coincident with write_dxy uses old velocity
    tick(3);                                   // P47
    set_dxy(2'sb10, 2'sb00);
    tick(1);                                   // P48
    write_dxy = 1'b0;
    chk("old_dx_x", 32'(sprite_x), 12);
    tick(4);                                   // P52
    chk("new_dx_x", 32'(sprite_x), 10);
    enable_update = 1'b0;

    // Level-sampled write_xy reloads every cycle
    set_xy(5, 5);
    tick(1);
    chk("level1_x", 32'(sprite_x), 5);
    set_xy(6, 6);
    tick(1);
    write_xy = 1'b0;
    chk("level2_x", 32'(sprite_x), 6);

    // Hit window for sprite at (20,30)
    set_xy(20, 30);
    pixel_x = 10'd27; pixel_y = 10'd37;
    tick(1);
    write_xy = 1'b0;
    chk("hit_pos_x", 32'(sprite_x), 20);
    tick(1);
    chk("hit_27_37", 32'(hit), 1);
    for (int i = 0; i < 5; i++) begin
      pixel_x = 10'(hit_vec[i][0]);
      pixel_y = 10'(hit_vec[i][1]);
      tick(1);
      chk($sformatf("hit_%0d_%0d", hit_vec[i][0], hit_vec[i][1]), 32'(hit), 32'(hit_vec[i][2]));
    end

    // Reset mid-flight
    set_xy(200, 0);
    pixel_x = 10'd200; pixel_y = 10'd0;
    tick(1);
    write_xy = 1'b0;
    chk("pre_rst_x", 32'(sprite_x), 200);
    tick(1);
    chk("pre_rst_hit", 32'(hit), 1);
    rst = 1'b1;
    #1;
    chk("arst_x", 32'(sprite_x), 0);
    chk("arst_within", 32'(within_screen), 1);
    chk("arst_hit", 32'(hit), 0);
    @(negedge clk);
    rst = 1'b0; enable_update = 1'b1;
    set_xy(200, 0); set_dxy(2'sb01, 2'sb00);
    pixel_x = 10'd500; pixel_y = 10'd400;
    tick(1);                                   // Q1
    write_xy = 1'b0; write_dxy = 1'b0;
    chk("post_rst_load", 32'(sprite_x), 200);
    tick(2);                                   // Q3
    chk("post_rst_nomove", 32'(sprite_x), 200);
    tick(1);                                   // Q4
    chk("post_rst_first", 32'(sprite_x), 201);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
